// File: rtl/pixel_ray_gen.sv
// Raster-scan primary-ray source: walks every pixel of a frame and emits an unnormalised
// float32 direction per pixel, tagged with its column/row, on a valid/ready stream.
module pixel_ray_gen #(
  parameter int         H_RES = 320,
  parameter int         V_RES = 180,
  parameter int         FOCAL = 256,
  parameter logic [1:0] SEL   = 2'b11
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic [95:0] ray_axis_tdata,
  output logic [10:0] hcount_axis_tdata,
  output logic [9:0]  vcount_axis_tdata,
  output logic [1:0]  select_objs,
  output logic        ray_axis_tvalid,
  input  logic        ray_axis_tready,
  output logic        busy,
  output logic        frame_done
);

  localparam int DATA_W = 32;
  localparam int INT_W  = 25;

  // Exact signed-integer to IEEE-754 single conversion; |value| < 2^24 so no rounding.
  function automatic logic [DATA_W-1:0] int_to_f32(input logic signed [INT_W-1:0] i_val);
    logic [INT_W-1:0] mag;
    logic [INT_W-1:0] norm;
    logic [7:0]       exp_b;
    int               lead;
    mag  = i_val[INT_W-1] ? INT_W'(-i_val) : INT_W'(i_val);
    lead = 0;
    for (int k = 0; k < INT_W - 1; k++) begin
      if (mag[k]) lead = k;
    end
    norm  = mag << (INT_W - 2 - lead);
    exp_b = 8'(127 + lead);
    if (mag == '0) return '0;
    return {i_val[INT_W-1], exp_b, norm[INT_W-3:0]};
  endfunction

  localparam logic signed [INT_W-1:0] HALF_H = INT_W'(H_RES / 2);
  localparam logic signed [INT_W-1:0] HALF_V = INT_W'(V_RES / 2);
  localparam logic [10:0]             H_LAST = 11'(H_RES - 1);
  localparam logic [9:0]              V_LAST = 10'(V_RES - 1);
  localparam logic [DATA_W-1:0]       Z_F32  = int_to_f32(INT_W'(-FOCAL));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_h;
  logic [10:0] w_h_nxt;
  logic [9:0]  r_v;
  logic [9:0]  w_v_nxt;
  logic        r_done;
  logic        w_done_nxt;

  logic signed [INT_W-1:0] w_x;
  logic signed [INT_W-1:0] w_y;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Counters move only on a handshake, so the presented pixel stays bit-stable under backpressure.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_v_nxt     = r_v;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_h_nxt     = '0;
          w_v_nxt     = '0;
        end
      end
      S_RUN: begin
        if (ray_axis_tready) begin
          if (r_h == H_LAST) begin
            w_h_nxt = '0;
            if (r_v == V_LAST) begin
              w_state_nxt = S_IDLE;
              w_v_nxt     = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_v_nxt = r_v + 10'd1;
            end
          end else begin
            w_h_nxt = r_h + 11'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_x = $signed({14'd0, r_h}) - HALF_H;
  assign w_y = HALF_V - $signed({15'd0, r_v});

  assign ray_axis_tdata    = {int_to_f32(w_x), int_to_f32(w_y), Z_F32};
  assign hcount_axis_tdata = r_h;
  assign vcount_axis_tdata = r_v;
  assign select_objs       = SEL;
  assign ray_axis_tvalid   = (r_state == S_RUN);
  assign busy              = (r_state == S_RUN);
  assign frame_done        = r_done;

endmodule

// File: tb/tb_pixel_ray_gen.sv
// Directed bench for pixel_ray_gen: a small 4x2 frame with a queue of expected pixels,
// plus one full default-size frame checked by count and end points.
module tb_pixel_ray_gen;

  localparam int H = 4;
  localparam int V = 2;
  localparam int F = 256;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start, tready, tvalid, busy, fdone;
  logic [95:0] tdata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [1:0]  sel;

  logic        d_start, d_tready, d_tvalid, d_busy, d_fdone;
  logic [95:0] d_data;
  logic [10:0] d_h;
  logic [9:0]  d_v;
  logic [1:0]  d_sel;

  always #5 aclk = ~aclk;

  pixel_ray_gen #(.H_RES(H), .V_RES(V), .FOCAL(F), .SEL(2'b11)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .ray_axis_tdata(tdata), .hcount_axis_tdata(hcount), .vcount_axis_tdata(vcount),
    .select_objs(sel), .ray_axis_tvalid(tvalid), .ray_axis_tready(tready),
    .busy(busy), .frame_done(fdone)
  );

  pixel_ray_gen dut_def (
    .aclk(aclk), .aresetn(aresetn), .start(d_start),
    .ray_axis_tdata(d_data), .hcount_axis_tdata(d_h), .vcount_axis_tdata(d_v),
    .select_objs(d_sel), .ray_axis_tvalid(d_tvalid), .ray_axis_tready(d_tready),
    .busy(d_busy), .frame_done(d_fdone)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [95:0] d;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           fd_cnt = 0;
  int           d_fd = 0;
  int           d_cnt = 0;
  int           fd0;
  int           c;
  logic         hold_v = 1'b0;
  logic [116:0] hold_d;
  logic [116:0] d_last;

  // Reference float built from the host double representation.
  function automatic logic [31:0] fb(input int val);
    logic [63:0] dbl;
    int          e;
    if (val == 0) return 32'h0;
    dbl = $realtobits(real'(val));
    e   = int'(dbl[62:52]) - 1023 + 127;
    return {dbl[63], e[7:0], dbl[51:29]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int vv = 0; vv < V; vv++) begin
      for (int hh = 0; hh < H; hh++) begin
        exp_t e;
        e.h = 11'(hh);
        e.v = 10'(vv);
        e.d = {fb(hh - H / 2), fb(V / 2 - vv), fb(-F)};
        sb.push_back(e);
      end
    end
  endtask

  // One clock: handshake/stability checks on the falling edge, then settle after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge aclk);
    if (hold_v && tvalid)
      chk("hold_stable", 128'({hcount, vcount, tdata}), 128'(hold_d));
    hold_v = tvalid && !tready;
    hold_d = {hcount, vcount, tdata};
    if (tvalid && tready) begin
      chk("sb_has_entry", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("pix_%0d_%0d", e.h, e.v), 128'({hcount, vcount, tdata}),
            128'({e.h, e.v, e.d}));
      end
    end
    if (d_tvalid && d_tready) begin
      d_cnt++;
      d_last = {d_h, d_v, d_data};
    end
    @(posedge aclk);
    #1;
    if (fdone) fd_cnt++;
    if (d_fdone) d_fd++;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int f0;
    int n;
    f0 = fd_cnt;
    n  = 0;
    while (fd_cnt == f0 && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, 128'(fd_cnt - f0), 128'(1));
  endtask

  initial begin
    start    = 1'b0;
    tready   = 1'b0;
    d_start  = 1'b0;
    d_tready = 1'b1;

    // Reset state
    repeat (2) cyc();
    chk("rst_tvalid", 128'(tvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(fdone), 128'(0));
    chk("rst_hv", 128'({hcount, vcount}), 128'(0));
    chk("rst_sel", 128'(sel), 128'(2'b11));
    aresetn = 1'b1;
    cyc();

    // Full-throughput frame
    tready = 1'b1;
    push_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_tvalid", 128'(tvalid), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_hv00", 128'({hcount, vcount}), 128'({11'd0, 10'd0}));
    chk("t1_data00", 128'(tdata), 128'({32'hC0000000, 32'h3F800000, 32'hC3800000}));
    repeat (2) cyc();
    chk("t4_hv20", 128'({hcount, vcount}), 128'({11'd2, 10'd0}));
    chk("t4_x_zero", 128'(tdata[95:64]), 128'(32'h00000000));
    chk("t4_y", 128'(tdata[63:32]), 128'(32'h3F800000));
    repeat (5) cyc();
    chk("t2_hv31", 128'({hcount, vcount}), 128'({11'd3, 10'd1}));
    chk("t2_x", 128'(tdata[95:64]), 128'(32'h3F800000));
    chk("t2_y", 128'(tdata[63:32]), 128'(32'h00000000));
    cyc();
    chk("t2_done_pulse", 128'(fdone), 128'(1));
    chk("t2_busy_drop", 128'(busy), 128'(0));
    chk("t2_tvalid_drop", 128'(tvalid), 128'(0));
    cyc();
    chk("t2_done_single", 128'(fdone), 128'(0));
    chk("t2_tvalid_low", 128'(tvalid), 128'(0));
    chk("t2_done_count", 128'(fd_cnt), 128'(1));
    chk("t2_sb_drained", 128'(sb.size()), 128'(0));

    // Random backpressure
    tready = 1'b0;
    push_frame();
    fd0 = fd_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    c = 0;
    while (fd_cnt == fd0 && c < 300) begin
      tready = 1'($urandom_range(0, 1));
      cyc();
      c++;
    end
    chk("t3_done_seen", 128'(fd_cnt - fd0), 128'(1));
    tready = 1'b1;
    repeat (3) cyc();
    chk("t3_done_once", 128'(fd_cnt - fd0), 128'(1));
    chk("t3_sb_drained", 128'(sb.size()), 128'(0));

    // Start held high for the whole frame
    push_frame();
    start = 1'b1;
    cyc();
    wait_done("t5_done_seen", 50);
    chk("t5_idle_at_done", 128'(tvalid), 128'(0));
    chk("t5_sb_drained", 128'(sb.size()), 128'(0));
    push_frame();
    cyc();
    start = 1'b0;
    chk("t5_restart_valid", 128'(tvalid), 128'(1));
    chk("t5_restart_hv", 128'({hcount, vcount}), 128'(0));
    wait_done("t5_second_done", 50);
    chk("t5_second_drained", 128'(sb.size()), 128'(0));

    // Reset in mid-frame
    push_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    chk("t6_at_11", 128'({hcount, vcount}), 128'({11'd1, 10'd1}));
    aresetn = 1'b0;
    fd0 = fd_cnt;
    cyc();
    aresetn = 1'b1;
    chk("t6_tvalid", 128'(tvalid), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_no_pulse", 128'(fdone), 128'(0));
    sb.delete();
    repeat (3) cyc();
    chk("t6_no_done", 128'(fd_cnt - fd0), 128'(0));
    chk("t6_stays_idle", 128'(tvalid), 128'(0));
    push_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_restart_hv", 128'({hcount, vcount}), 128'(0));
    chk("t6_restart_valid", 128'(tvalid), 128'(1));
    wait_done("t6_done_seen", 50);
    chk("t6_sb_drained", 128'(sb.size()), 128'(0));

    // Default-size frame
    d_cnt = 0;
    fd0 = d_fd;
    d_start = 1'b1;
    cyc();
    d_start = 1'b0;
    chk("def_busy", 128'(d_busy), 128'(1));
    chk("def_sel", 128'(d_sel), 128'(2'b11));
    chk("def_first_hv", 128'({d_h, d_v}), 128'(0));
    chk("def_first_data", 128'(d_data), 128'({32'hC3200000, 32'h42B40000, 32'hC3800000}));
    c = 0;
    while (d_fd == fd0 && c < 60000) begin
      cyc();
      c++;
    end
    chk("def_done_seen", 128'(d_fd - fd0), 128'(1));
    chk("def_ray_count", 128'(d_cnt), 128'(57600));
    chk("def_last_hv", 128'(d_last[116:96]), 128'({11'd319, 10'd179}));
    chk("def_last_data", 128'(d_last[95:0]), 128'({32'h431F0000, 32'hC2B20000, 32'hC3800000}));
    chk("def_last_model", 128'(d_last[95:0]), 128'({fb(159), fb(-89), fb(-256)}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
